button_pulse_gen: RTL and testbench
===================================

# button_pulse_gen

Conditions a raw push-button into the single-cycle count-enable pulse consumed by the board's decade counter stage. It synchronizes and debounces the asynchronous button. It emits exactly one clock-wide pulse per confirmed press. An optional auto-repeat stream follows while the button is held.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required to accept a press or release (≥1)
- HOLD_CYCLES, 50_000_000: cycles from first pulse to first repeat pulse (≥1)
- REPEAT_CYCLES, 10_000_000: cycles between repeat pulses (≥1)
- CNT_W, 26: timer width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)−1
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- btn_in  input  1  raw button, asynchronous, active-high, bouncy
- repeat_en  input  1  synchronous; enables auto-repeat while held
- pulse  output  1  one-cycle enable pulse (drives counter enable input)
- pressed  output  1  debounced button level

## Operation
- 2-FF synchronizer on btn_in → btn_s; both flops reset to 0.
- Single timer cnt (CNT_W bits), cleared on every state change.
- FSM states: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB; reset state IDLE.
- IDLE: btn_s=1 → PRESS_DB.
- PRESS_DB: btn_s=0 → IDLE, with no pulse (bounce rejected). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES−1 with btn_s=1 → HELD, pulse=1.
- HELD: btn_s=0 → RELEASE_DB. Else if repeat_en and cnt==HOLD_CYCLES−1 → REPEAT, pulse=1. Else cnt++ (saturating when repeat_en=0).
- REPEAT: btn_s=0 → RELEASE_DB. repeat_en=0 → HELD, with no pulse. cnt==REPEAT_CYCLES−1 → stay, pulse=1, cnt=0. Else cnt++.
- RELEASE_DB: btn_s=1 → HELD, cnt=0, no pulse (release bounce). Reaching cnt==DEBOUNCE_CYCLES−1 with btn_s=0 → IDLE.
- Release takes priority over repeat when both occur in the same cycle.
- pressed=1 in HELD, REPEAT, RELEASE_DB; 0 otherwise.
- pulse and pressed are registered outputs; no combinational path from inputs.

## Timing
- Reset values: pulse=0, pressed=0, state=IDLE, cnt=0, synchronizer=0. Assertion takes effect immediately; a pulse in flight is cleared.
- Press latency: btn_in stably high from clock edge k. pulse and pressed rise at edge k+DEBOUNCE_CYCLES+3: 2 synchronizer edges, 1 entry edge, then DEBOUNCE_CYCLES timer edges.
- pulse is high for exactly one cycle per event and is never high on two consecutive cycles.
- First repeat pulse comes HOLD_CYCLES cycles after the press pulse. Subsequent repeat pulses come every REPEAT_CYCLES cycles.
- Release latency: btn_in low from edge k; pressed falls at edge k+DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES in PRESS_DB produces no pulse. The same glitch in RELEASE_DB produces no new pulse.
- rst released mid-press: the block restarts from IDLE and a still-held button is debounced again.

## Structure
- Shared package/header: FSM state encoding constants (3-bit) for reuse by the downstream counter's testbench monitors.
- Sub-module: sync_2ff (generic 2-flop synchronizer, async reset to 0), instantiated once.
- The FSM and timer live in this module.

## Test plan
Bench overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, CNT_W=4.
- Clean press: btn_in 0→1 at edge 5, held 20 cycles, repeat_en=0 → single pulse at edge 12; pressed high from 12; no further pulses.
- Bounce: btn_in high 2 cycles, low 1, high 2, then low → no pulse; pressed stays 0.
- Auto-repeat: repeat_en=1, btn held 30 cycles → pulses at press+0, +10, +13, +16, … until release; each pulse 1 cycle wide.
- Release bounce: after HELD, btn_in low 2 cycles then high again → no pulse, pressed stays 1. A later clean release drops pressed 7 edges after btn_in falls.
- Reset mid-operation: assert rst while in REPEAT → pulse=0, pressed=0 immediately. Deassert with btn still high → new pulse 7 edges after the first sampled high.
- Integration: 12 clean presses feeding the decade counter enable → counter reads 2 (wrap through 9→0), confirming one increment per press.

Source files
------------

// File: rtl/button_pulse_gen_pkg.sv
// Shared definitions for the push-button conditioner: 3-bit FSM state encoding,
// exported so downstream benches and monitors can decode the state register.
package button_pulse_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } bpg_state_e;

  function automatic logic is_pressed_state(input bpg_state_e s);
    return (s == ST_HELD) || (s == ST_REPEAT) || (s == ST_RELEASE_DB);
  endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button-side signal bundle: raw button and repeat enable in, count-enable pulse
// and debounced level out.
interface button_pulse_gen_if;
  logic btn_in;
  logic repeat_en;
  logic pulse;
  logic pressed;

  modport master (output btn_in, output repeat_en, input pulse, input pressed);
  modport slave  (input btn_in, input repeat_en, output pulse, output pressed);
endinterface

// File: rtl/button_pulse_gen_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; both stages reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronize, debounce, emit one count-enable pulse per
// press, with optional auto-repeat while held. Outputs are registered.
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input logic               clk,
  input logic               rst,
  button_pulse_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic btn_s;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (btn_s)
  );

  bpg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             pressed_q, pressed_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    pulse_d = 1'b0;
    // Release (btn_s low) is tested first in every held state so it wins over repeat.
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (bus.repeat_en && cnt_q == HOLD_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = cnt_q;
        end
      end
      ST_REPEAT: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (!bus.repeat_en) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        if (btn_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pressed_d = is_pressed_state(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  assign bus.pulse   = pulse_q;
  assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with short timing parameters and a
// decade-counter model fed by the pulse output.
module tb_button_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_pulse_gen_if bus ();

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .CNT_W           (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic        dec_clr;
  logic [3:0]  dec_q;
  int unsigned pulse_total;

  always @(posedge clk) begin
    if (dec_clr) begin
      dec_q       <= 4'd0;
      pulse_total <= 0;
    end else if (bus.pulse) begin
      dec_q       <= (dec_q == 4'd9) ? 4'd0 : dec_q + 4'd1;
      pulse_total <= pulse_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int i, input logic exp_pulse,
                             input logic exp_pressed);
    check($sformatf("%s.pulse@%0d", tag, i), {31'd0, bus.pulse}, {31'd0, exp_pulse});
    check($sformatf("%s.pressed@%0d", tag, i), {31'd0, bus.pressed}, {31'd0, exp_pressed});
  endtask

  initial begin
    rst           = 1'b1;
    bus.btn_in    = 1'b0;
    bus.repeat_en = 1'b0;
    dec_clr       = 1'b1;
    tick();
    tick();
    check_cycle("reset", 0, 1'b0, 1'b0);
    rst     = 1'b0;
    dec_clr = 1'b0;
    tick();
    tick();
    tick();

    // Clean press, no repeat: one pulse 7 edges after the rise, then release.
    bus.btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_cycle("press", i, i == 7, i >= 7);
    end
    bus.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle("release", i, 1'b0, i < 7);
    end

    // Bounce: high 2, low 1, high 2, then low: never accepted.
    for (int i = 1; i <= 14; i++) begin
      bus.btn_in = (i <= 2) || (i == 4) || (i == 5);
      tick();
      check_cycle("bounce", i, 1'b0, 1'b0);
    end

    // Auto-repeat; release lands on a repeat slot (edge 35) and must win.
    bus.repeat_en = 1'b1;
    bus.btn_in    = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      if (i == 33) bus.btn_in = 1'b0;
      tick();
      check_cycle("repeat", i,
                  (i == 7) || (i >= 17 && i <= 32 && ((i - 17) % 3) == 0),
                  (i >= 7) && (i < 39));
    end
    bus.repeat_en = 1'b0;

    // Release bounce: short low excursion while HELD keeps pressed, no pulse.
    bus.btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle("rb_press", i, i == 7, i >= 7);
    end
    for (int i = 1; i <= 12; i++) begin
      bus.btn_in = (i > 2);
      tick();
      check_cycle("rb_bounce", i, 1'b0, 1'b1);
    end
    bus.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle("rb_release", i, 1'b0, i < 7);
    end

    // Reset asserted while a repeat pulse is out; held button re-debounced after.
    bus.repeat_en = 1'b1;
    bus.btn_in    = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_cycle("pre_rst", i, (i == 7) || (i == 17) || (i == 20), i >= 7);
    end
    rst = 1'b1;
    #1;
    check_cycle("rst_async", 0, 1'b0, 1'b0);
    tick();
    tick();
    check_cycle("rst_held", 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle("post_rst", i, i == 7, i >= 7);
    end
    bus.btn_in    = 1'b0;
    bus.repeat_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle("post_rst_rel", i, 1'b0, i < 7);
    end

    // Integration: 12 clean presses into a decade counter wrap it to 2.
    dec_clr = 1'b1;
    tick();
    dec_clr = 1'b0;
    for (int p = 0; p < 12; p++) begin
      bus.btn_in = 1'b1;
      repeat (12) tick();
      bus.btn_in = 1'b0;
      repeat (12) tick();
    end
    check("dec_count", {28'd0, dec_q}, 32'd2);
    check("pulse_total", pulse_total, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
